// File: rtl/clint_irq_ctrl.sv
// Machine-mode interrupt controller behind the CLINT: registers timer/software/external
// sources, exposes the mip view and runs a one-at-a-time request/ack handshake with the core.
module clint_irq_ctrl #(
  parameter int unsigned SYNC_MEIP = 1,
  parameter int unsigned XLEN      = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] mtime,
  input  logic [XLEN-1:0] mtimecmp,
  input  logic            msip,
  input  logic            meip,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie,
  input  logic            irq_ack,
  input  logic            mret,
  output logic            irq_req,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mip_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            mtip_q, mtip_d;
  logic            msip_q, msip_d;
  logic            meip_q;
  logic            en_mei, en_msi, en_mti;
  logic [3:0]      sel_code;
  logic            latched_pending;

  // Only mie bits 3, 7 and 11 take part in selection.
  logic            unused_mie;
  assign unused_mie = ^{mie[XLEN-1:12], mie[10:8], mie[6:4], mie[2:0]};

  assign mtip_d = (mtime >= mtimecmp);
  assign msip_d = msip;

  if (SYNC_MEIP != 0) begin : g_meip_sync
    logic meip_s1_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        meip_s1_q <= 1'b0;
        meip_q    <= 1'b0;
      end else begin
        meip_s1_q <= meip;
        meip_q    <= meip_s1_q;
      end
    end
  end else begin : g_meip_reg
    always_ff @(posedge clk) begin
      if (rst) meip_q <= 1'b0;
      else     meip_q <= meip;
    end
  end

  always_comb begin
    en_mei = meip_q & mie[11];
    en_msi = msip_q & mie[3];
    en_mti = mtip_q & mie[7];

    if (en_mei)      sel_code = 4'd11;
    else if (en_msi) sel_code = 4'd3;
    else             sel_code = 4'd7;

    // The presented cause identifies which source must stay pending while in REQ.
    case (mcause_q[3:0])
      4'd11:   latched_pending = en_mei;
      4'd3:    latched_pending = en_msi;
      4'd7:    latched_pending = en_mti;
      default: latched_pending = 1'b0;
    endcase

    state_d  = state_q;
    mcause_d = mcause_q;
    case (state_q)
      IDLE: begin
        if (mstatus_mie && (en_mei || en_msi || en_mti)) begin
          state_d  = REQ;
          mcause_d = {1'b1, {(XLEN-5){1'b0}}, sel_code};
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d = ACTIVE;
        end else if (!latched_pending || !mstatus_mie) begin
          state_d  = IDLE;
          mcause_d = '0;
        end
      end
      ACTIVE: begin
        if (mret) begin
          state_d  = IDLE;
          mcause_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        mcause_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcause_q <= '0;
      mtip_q   <= 1'b0;
      msip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcause_q <= mcause_d;
      mtip_q   <= mtip_d;
      msip_q   <= msip_d;
    end
  end

  always_comb begin
    mip_o     = '0;
    mip_o[3]  = msip_q;
    mip_o[7]  = mtip_q;
    mip_o[11] = meip_q;
  end

  assign irq_req  = (state_q == REQ);
  assign busy_o   = (state_q == ACTIVE);
  assign mcause_o = mcause_q;

endmodule
